// File: rtl/bp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bp_pkg
// Purpose  : Shared types, constants and helpers for the agree branch
//            predictor: the 2-bit agree counter, its reset/saturation
//            values and a saturating update function.
// Revision : 1.0 - initial release
// ============================================================================
package bp_pkg;

  // 2-bit agree counter: bit 1 set means "agree with the BTB bias".
  typedef logic [1:0] ctr_t;

  localparam ctr_t CTR_INIT = 2'b10;  // weak agree
  localparam ctr_t CTR_MAX  = 2'b11;  // strong agree
  localparam ctr_t CTR_MIN  = 2'b00;  // strong disagree

  // Saturating increment (up=1) or decrement (up=0).
  function automatic ctr_t ctr_sat(input ctr_t c, input logic up);
    ctr_t r;
    r = c;
    if (up) begin
      if (c != CTR_MAX) r = c + 2'd1;
    end else begin
      if (c != CTR_MIN) r = c - 2'd1;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/agree_pht.sv
`default_nettype none
// ============================================================================
// Module   : agree_pht
// Purpose  : Table of 2**PHT_WIDTH agree counters. One combinational read
//            port and one synchronous write port that either trains the
//            addressed counter (saturating up/down) or forces it to CTR_INIT.
// Ports    : clk_i, rst_ni (async, active-high)
//            rd_idx_i / rd_ctr_o          - combinational read
//            wr_en_i, wr_init_i, wr_up_i,
//            wr_idx_i                     - synchronous write
// Revision : 1.0 - initial release
// ============================================================================
module agree_pht
  import bp_pkg::*;
#(
  parameter int PHT_WIDTH = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [PHT_WIDTH-1:0] rd_idx_i,
  output ctr_t                 rd_ctr_o,
  input  logic                 wr_en_i,
  input  logic                 wr_init_i,
  input  logic                 wr_up_i,
  input  logic [PHT_WIDTH-1:0] wr_idx_i
);

  localparam int ENTRIES = 2 ** PHT_WIDTH;

  ctr_t ctr_q [ENTRIES];

  // Read sees the pre-edge contents, so a same-cycle write to the same
  // entry is not forwarded.
  assign rd_ctr_o = ctr_q[rd_idx_i];

  always_ff @(posedge clk_i or posedge rst_ni) begin
    if (rst_ni) begin
      for (int i = 0; i < ENTRIES; i++) begin
        ctr_q[i] <= CTR_INIT;
      end
    end else if (wr_en_i) begin
      ctr_q[wr_idx_i] <= wr_init_i ? CTR_INIT : ctr_sat(ctr_q[wr_idx_i], wr_up_i);
    end
  end

endmodule
`default_nettype wire

// File: rtl/agree_branch_predictor.sv
`default_nettype none
// ============================================================================
// Module   : agree_branch_predictor
// Purpose  : Fetch-stage agree direction predictor in front of a BTB.
//            Combines a gshare-indexed agree counter with the BTB bias to
//            predict the next PC; trains counters, repairs global history
//            and drives the BTB write port on EX resolution.
// Ports    : fetch side  - fetch_pc_i, fetch_en_i, btb_rd_index_o,
//                          btb_valid_i/bias_i/tag_i/target_i,
//                          pred_hit_o/taken_o/pc_o/ghr_o
//            update side - upd_* inputs
//            BTB write   - btb_wren_o, btb_wr_index_o/tag_o/target_o,
//                          btb_br_taken_o (all registered)
// Revision : 1.0 - initial release
// ============================================================================
module agree_branch_predictor
  import bp_pkg::*;
#(
  parameter int INDEX_WIDTH = 6,
  parameter int PHT_WIDTH   = 8,
  parameter int GHR_WIDTH   = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [31:0]             fetch_pc_i,
  input  logic                    fetch_en_i,
  output logic [INDEX_WIDTH-1:0]  btb_rd_index_o,
  input  logic                    btb_valid_i,
  input  logic                    btb_bias_i,
  input  logic [29-INDEX_WIDTH:0] btb_tag_i,
  input  logic [31:0]             btb_target_i,
  output logic                    pred_hit_o,
  output logic                    pred_taken_o,
  output logic [31:0]             pred_pc_o,
  output logic [GHR_WIDTH-1:0]    pred_ghr_o,
  input  logic                    upd_valid_i,
  input  logic [31:0]             upd_pc_i,
  input  logic [31:0]             upd_target_i,
  input  logic [GHR_WIDTH-1:0]    upd_ghr_i,
  input  logic                    upd_hit_i,
  input  logic                    upd_bias_i,
  input  logic                    upd_is_branch_i,
  input  logic                    upd_taken_i,
  input  logic                    upd_mispredict_i,
  output logic                    btb_wren_o,
  output logic [INDEX_WIDTH-1:0]  btb_wr_index_o,
  output logic [29-INDEX_WIDTH:0] btb_wr_tag_o,
  output logic [31:0]             btb_wr_target_o,
  output logic                    btb_br_taken_o
);

  localparam int TAG_WIDTH = 30 - INDEX_WIDTH;

  logic [GHR_WIDTH-1:0]   ghr_q, ghr_d;
  logic [PHT_WIDTH-1:0]   rd_idx, upd_idx;
  ctr_t                   rd_ctr;
  logic                   hit, taken;
  logic                   upd_br, do_train, do_alloc, do_retarget;

  logic                   wren_q, wren_d;
  logic [INDEX_WIDTH-1:0] wr_index_q, wr_index_d;
  logic [TAG_WIDTH-1:0]   wr_tag_q, wr_tag_d;
  logic [31:0]            wr_target_q, wr_target_d;
  logic                   br_taken_q, br_taken_d;

  // Byte-offset bits never participate in indexing or tags.
  logic unused_ok;
  assign unused_ok = ^{fetch_pc_i[1:0], upd_pc_i[1:0]};

  // ---------------- prediction (combinational) ----------------
  assign btb_rd_index_o = fetch_pc_i[INDEX_WIDTH+1:2];
  assign hit    = btb_valid_i & (btb_tag_i == fetch_pc_i[31:INDEX_WIDTH+2]);
  assign rd_idx = fetch_pc_i[PHT_WIDTH+1:2] ^ PHT_WIDTH'(ghr_q);
  // Counter MSB set: follow the bias; clear: invert it.
  assign taken  = hit & ~(rd_ctr[1] ^ btb_bias_i);

  assign pred_hit_o   = hit;
  assign pred_taken_o = taken;
  assign pred_pc_o    = taken ? btb_target_i : fetch_pc_i + 32'd4;
  assign pred_ghr_o   = ghr_q;

  // ---------------- resolution ----------------
  assign upd_idx     = upd_pc_i[PHT_WIDTH+1:2] ^ PHT_WIDTH'(upd_ghr_i);
  assign upd_br      = upd_valid_i & upd_is_branch_i;
  assign do_train    = upd_br & upd_hit_i;
  assign do_alloc    = upd_br & ~upd_hit_i & upd_taken_i;
  // Hit, taken and still mispredicted: the stored target was wrong.
  assign do_retarget = upd_br & upd_hit_i & upd_taken_i & upd_mispredict_i;

  agree_pht #(
    .PHT_WIDTH (PHT_WIDTH)
  ) u_pht (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .rd_idx_i  (rd_idx),
    .rd_ctr_o  (rd_ctr),
    .wr_en_i   (do_train | do_alloc),
    .wr_init_i (do_alloc),
    .wr_up_i   (upd_taken_i == upd_bias_i),
    .wr_idx_i  (upd_idx)
  );

  // History: a resolved mispredict overrides any speculative shift.
  always_comb begin
    ghr_d = ghr_q;
    if (upd_valid_i & upd_mispredict_i) begin
      if (upd_hit_i & upd_is_branch_i) begin
        ghr_d = {upd_ghr_i[GHR_WIDTH-2:0], upd_taken_i};
      end else begin
        ghr_d = upd_ghr_i;
      end
    end else if (fetch_en_i & hit) begin
      ghr_d = {ghr_q[GHR_WIDTH-2:0], taken};
    end
  end

  // BTB write payload is loaded only on a write so the bus stays quiet.
  always_comb begin
    wren_d      = do_alloc | do_retarget;
    wr_index_d  = wr_index_q;
    wr_tag_d    = wr_tag_q;
    wr_target_d = wr_target_q;
    br_taken_d  = br_taken_q;
    if (do_alloc | do_retarget) begin
      wr_index_d  = upd_pc_i[INDEX_WIDTH+1:2];
      wr_tag_d    = upd_pc_i[31:INDEX_WIDTH+2];
      wr_target_d = upd_target_i;
      // Bias is fixed at allocation and carried unchanged on retarget.
      br_taken_d  = do_alloc ? 1'b1 : upd_bias_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_ni) begin
    if (rst_ni) begin
      ghr_q       <= '0;
      wren_q      <= 1'b0;
      wr_index_q  <= '0;
      wr_tag_q    <= '0;
      wr_target_q <= '0;
      br_taken_q  <= 1'b0;
    end else begin
      ghr_q       <= ghr_d;
      wren_q      <= wren_d;
      wr_index_q  <= wr_index_d;
      wr_tag_q    <= wr_tag_d;
      wr_target_q <= wr_target_d;
      br_taken_q  <= br_taken_d;
    end
  end

  assign btb_wren_o      = wren_q;
  assign btb_wr_index_o  = wr_index_q;
  assign btb_wr_tag_o    = wr_tag_q;
  assign btb_wr_target_o = wr_target_q;
  assign btb_br_taken_o  = br_taken_q;

endmodule
`default_nettype wire

// File: tb/tb_agree_branch_predictor.sv
`default_nettype none
// ============================================================================
// Module   : tb_agree_branch_predictor
// Purpose  : Directed-vector bench for agree_branch_predictor. Stimulus
//            pushes expected output values tagged with a cycle number into
//            a scoreboard queue; a monitor compares them on the falling edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_agree_branch_predictor;

  localparam int IW = 6;
  localparam int PW = 8;
  localparam int GW = 8;

  localparam int S_HIT = 0, S_TAKEN = 1, S_PC = 2, S_GHR = 3, S_WREN = 4,
                 S_WIDX = 5, S_WTAG = 6, S_WTGT = 7, S_WBR = 8;

  logic          clk = 1'b0;
  logic          rst_ni = 1'b1;
  logic [31:0]   fetch_pc_i = '0;
  logic          fetch_en_i = 1'b0;
  logic [IW-1:0] btb_rd_index_o;
  logic          btb_valid_i = 1'b0, btb_bias_i = 1'b0;
  logic [29-IW:0] btb_tag_i = '0;
  logic [31:0]   btb_target_i = '0;
  logic          pred_hit_o, pred_taken_o;
  logic [31:0]   pred_pc_o;
  logic [GW-1:0] pred_ghr_o;
  logic          upd_valid_i = 1'b0;
  logic [31:0]   upd_pc_i = '0, upd_target_i = '0;
  logic [GW-1:0] upd_ghr_i = '0;
  logic          upd_hit_i = 1'b0, upd_bias_i = 1'b0, upd_is_branch_i = 1'b0;
  logic          upd_taken_i = 1'b0, upd_mispredict_i = 1'b0;
  logic          btb_wren_o;
  logic [IW-1:0] btb_wr_index_o;
  logic [29-IW:0] btb_wr_tag_o;
  logic [31:0]   btb_wr_target_o;
  logic          btb_br_taken_o;

  agree_branch_predictor #(
    .INDEX_WIDTH (IW),
    .PHT_WIDTH   (PW),
    .GHR_WIDTH   (GW)
  ) dut (
    .clk_i            (clk),
    .rst_ni           (rst_ni),
    .fetch_pc_i       (fetch_pc_i),
    .fetch_en_i       (fetch_en_i),
    .btb_rd_index_o   (btb_rd_index_o),
    .btb_valid_i      (btb_valid_i),
    .btb_bias_i       (btb_bias_i),
    .btb_tag_i        (btb_tag_i),
    .btb_target_i     (btb_target_i),
    .pred_hit_o       (pred_hit_o),
    .pred_taken_o     (pred_taken_o),
    .pred_pc_o        (pred_pc_o),
    .pred_ghr_o       (pred_ghr_o),
    .upd_valid_i      (upd_valid_i),
    .upd_pc_i         (upd_pc_i),
    .upd_target_i     (upd_target_i),
    .upd_ghr_i        (upd_ghr_i),
    .upd_hit_i        (upd_hit_i),
    .upd_bias_i       (upd_bias_i),
    .upd_is_branch_i  (upd_is_branch_i),
    .upd_taken_i      (upd_taken_i),
    .upd_mispredict_i (upd_mispredict_i),
    .btb_wren_o       (btb_wren_o),
    .btb_wr_index_o   (btb_wr_index_o),
    .btb_wr_tag_o     (btb_wr_tag_o),
    .btb_wr_target_o  (btb_wr_target_o),
    .btb_br_taken_o   (btb_br_taken_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    int          sig;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  task automatic exp_push(input int sig, input logic [31:0] v, input string name);
    exp_t e;
    e.cyc  = cyc;
    e.sig  = sig;
    e.exp  = v;
    e.name = name;
    sb.push_back(e);
  endtask

  function automatic logic [31:0] actual(input int sig);
    logic [31:0] a;
    a = '0;
    case (sig)
      S_HIT:   a = {31'd0, pred_hit_o};
      S_TAKEN: a = {31'd0, pred_taken_o};
      S_PC:    a = pred_pc_o;
      S_GHR:   a = 32'(pred_ghr_o);
      S_WREN:  a = {31'd0, btb_wren_o};
      S_WIDX:  a = 32'(btb_wr_index_o);
      S_WTAG:  a = 32'(btb_wr_tag_o);
      S_WTGT:  a = btb_wr_target_o;
      S_WBR:   a = {31'd0, btb_br_taken_o};
      default: a = 32'hDEAD_BEEF;
    endcase
    return a;
  endfunction

  initial begin
    exp_t        e;
    logic [31:0] a;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        a = actual(e.sig);
        total_cnt++;
        if (a === e.exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)",
                      e.name, a, e.exp, cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_upd();
    upd_valid_i = 0; upd_pc_i = '0; upd_target_i = '0; upd_ghr_i = '0;
    upd_hit_i = 0; upd_bias_i = 0; upd_is_branch_i = 0;
    upd_taken_i = 0; upd_mispredict_i = 0;
  endtask

  task automatic set_fetch(input logic [31:0] pc, input logic v, input logic [23:0] tag,
                           input logic bias, input logic [31:0] tgt, input logic en);
    fetch_pc_i = pc; btb_valid_i = v; btb_tag_i = tag;
    btb_bias_i = bias; btb_target_i = tgt; fetch_en_i = en;
  endtask

  task automatic set_upd(input logic [31:0] pc, input logic [31:0] tgt, input logic [7:0] ghr,
                         input logic hit, input logic bias, input logic br,
                         input logic tk, input logic mp);
    upd_valid_i = 1; upd_pc_i = pc; upd_target_i = tgt; upd_ghr_i = ghr;
    upd_hit_i = hit; upd_bias_i = bias; upd_is_branch_i = br;
    upd_taken_i = tk; upd_mispredict_i = mp;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst_ni = 0;

    set_fetch(32'h100, 0, 24'h0, 0, 32'h0, 0);
    #1;
    total_cnt++;
    if (pred_pc_o === 32'h104) pass_cnt++;
    else $display("FAIL direct_rst_pc: got 0x%08h expected 0x00000104", pred_pc_o);
    total_cnt++;
    if (pred_taken_o === 1'b0) pass_cnt++;
    else $display("FAIL direct_rst_taken: got %b expected 0", pred_taken_o);
    total_cnt++;
    if (btb_wren_o === 1'b0) pass_cnt++;
    else $display("FAIL direct_rst_wren: got %b expected 0", btb_wren_o);
    exp_push(S_PC, 32'h104, "rst_pred_pc");
    exp_push(S_TAKEN, 0, "rst_taken");
    exp_push(S_HIT, 0, "rst_hit");
    exp_push(S_GHR, 0, "rst_ghr");
    exp_push(S_WREN, 0, "rst_wren");
    exp_push(S_WIDX, 0, "rst_widx");
    exp_push(S_WTAG, 0, "rst_wtag");
    exp_push(S_WTGT, 0, "rst_wtgt");
    exp_push(S_WBR, 0, "rst_wbr");

    tick();
    set_upd(32'h200, 32'h80, 8'h00, 0, 0, 1, 1, 0);
    exp_push(S_WREN, 0, "alloc_wren_not_yet");
    tick();
    clear_upd();
    total_cnt++;
    if (btb_wren_o === 1'b1) pass_cnt++;
    else $display("FAIL direct_alloc_wren: got %b expected 1", btb_wren_o);
    total_cnt++;
    if (btb_wr_target_o === 32'h80) pass_cnt++;
    else $display("FAIL direct_alloc_wtgt: got 0x%08h expected 0x00000080", btb_wr_target_o);
    exp_push(S_WREN, 1, "alloc_wren");
    exp_push(S_WIDX, 0, "alloc_widx");
    exp_push(S_WTAG, 32'h2, "alloc_wtag");
    exp_push(S_WTGT, 32'h80, "alloc_wtgt");
    exp_push(S_WBR, 1, "alloc_wbr");
    tick();
    exp_push(S_WREN, 0, "alloc_wren_pulse");

    set_fetch(32'h200, 1, 24'h2, 1, 32'h80, 0);
    exp_push(S_HIT, 1, "hit_hit");
    exp_push(S_TAKEN, 1, "hit_taken");
    exp_push(S_PC, 32'h80, "hit_pc");
    tick();

    for (int k = 0; k < 3; k++) begin
      set_upd(32'h200, 32'h80, 8'h00, 1, 1, 1, 0, 0);
      exp_push(S_TAKEN, (k == 0) ? 32'd1 : 32'd0, "down_taken");
      tick();
    end
    clear_upd();
    exp_push(S_TAKEN, 0, "sat_low_taken");
    exp_push(S_PC, 32'h204, "sat_low_pc");
    tick();
    for (int k = 0; k < 2; k++) begin
      set_upd(32'h200, 32'h80, 8'h00, 1, 1, 1, 1, 0);
      exp_push(S_TAKEN, 0, "up_taken");
      tick();
    end
    clear_upd();
    exp_push(S_TAKEN, 1, "recover_taken");
    exp_push(S_PC, 32'h80, "recover_pc");
    tick();

    set_fetch(32'h200, 1, 24'h2, 1, 32'h80, 1);
    exp_push(S_TAKEN, 1, "spec1_taken");
    exp_push(S_GHR, 0, "spec1_ghr");
    tick();
    set_fetch(32'h200, 1, 24'h2, 0, 32'h80, 1);
    exp_push(S_TAKEN, 0, "spec2_taken");
    exp_push(S_PC, 32'h204, "spec2_pc");
    exp_push(S_GHR, 1, "spec2_ghr");
    tick();
    set_fetch(32'h200, 0, 24'h2, 0, 32'h80, 0);
    exp_push(S_GHR, 2, "spec_ghr_10");
    tick();
    set_fetch(32'h200, 1, 24'h2, 1, 32'h80, 1);
    set_upd(32'h200, 32'h80, 8'h05, 1, 1, 1, 1, 1);
    exp_push(S_TAKEN, 1, "rec_fetch_taken");
    tick();
    clear_upd();
    set_fetch(32'h200, 0, 24'h2, 0, 32'h80, 0);
    exp_push(S_GHR, 32'h0B, "rec_hit_ghr");
    tick();
    set_upd(32'h0, 32'h0, 8'h5A, 0, 0, 0, 0, 1);
    tick();
    clear_upd();
    exp_push(S_GHR, 32'h5A, "rec_miss_ghr");

    set_upd(32'h1F4, 32'h300, 8'h5A, 1, 0, 1, 1, 1);
    tick();
    clear_upd();
    exp_push(S_WREN, 1, "rt_wren");
    exp_push(S_WIDX, 32'h3D, "rt_widx");
    exp_push(S_WTAG, 32'h1, "rt_wtag");
    exp_push(S_WTGT, 32'h300, "rt_wtgt");
    exp_push(S_WBR, 0, "rt_wbr");
    exp_push(S_GHR, 32'hB5, "rt_ghr");
    set_upd(32'h1F4, 32'h300, 8'h00, 1, 1, 1, 1, 0);
    tick();
    clear_upd();
    exp_push(S_WREN, 0, "ok_no_wren");
    exp_push(S_GHR, 32'hB5, "ok_ghr_hold");

    set_fetch(32'h248, 1, 24'h2, 1, 32'h500, 0);
    set_upd(32'h400, 32'h44, 8'h00, 0, 0, 1, 1, 0);
    exp_push(S_TAKEN, 0, "pre_rst_taken");
    exp_push(S_PC, 32'h24C, "pre_rst_pc");
    tick();
    clear_upd();
    exp_push(S_WREN, 1, "pend_wren");
    exp_push(S_WTGT, 32'h44, "pend_wtgt");
    @(negedge clk);
    #1;
    rst_ni = 1;
    #1;
    exp_push(S_WREN, 0, "midrst_wren");
    exp_push(S_GHR, 0, "midrst_ghr");
    exp_push(S_WTGT, 0, "midrst_wtgt");
    exp_push(S_WTAG, 0, "midrst_wtag");
    tick();
    rst_ni = 0;
    set_fetch(32'h9C, 1, 24'h0, 1, 32'h500, 0);
    #1;
    total_cnt++;
    if (pred_taken_o === 1'b1) pass_cnt++;
    else $display("FAIL direct_post_rst_taken: got %b expected 1", pred_taken_o);
    total_cnt++;
    if (pred_pc_o === 32'h500) pass_cnt++;
    else $display("FAIL direct_post_rst_pc: got 0x%08h expected 0x00000500", pred_pc_o);
    exp_push(S_TAKEN, 1, "post_rst_taken");
    exp_push(S_PC, 32'h500, "post_rst_pc");
    tick();
    tick();
    @(negedge clk);
    #1;

    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      total_cnt++;
      $display("FAIL %s: got none expected 0x%08h (never checked)", e.name, e.exp);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
